prim_sync_debounce: RTL and testbench
=====================================

Name: prim_sync_debounce

Overview:
Multi-channel input conditioner for asynchronous pins such as GPIO, straps and wakeup lines. Each bit is brought into clk_i through a two-flop synchronizer. A per-channel stability counter then rejects glitches shorter than a programmable threshold. The block outputs the filtered level plus single-cycle rise/fall event pulses for interrupt logic in the same clock domain.

Parameters:
Width, 8, number of independent channels
CntWidth, 4, bits of the per-channel stability counter and of thresh_i
ResetValue, 0, reset level (1 bit) of the sync stages and q_o for every channel

Ports:
clk_i  input  1  sole clock
rst_ni  input  1  reset, asynchronous, active-low
d_i  input  Width  raw asynchronous inputs
en_i  input  Width  per-channel filter enable
thresh_i  input  CntWidth  shared debounce threshold T, quasi-static, read live every cycle
q_o  output  Width  filtered, debounced level
rise_o  output  Width  1-cycle pulse when q_o goes 0->1
fall_o  output  Width  1-cycle pulse when q_o goes 1->0

Behaviour:
- Interface: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset (asynchronous assert, synchronous-release expected upstream):
  - sync flops and q_o = {Width{ResetValue}}
  - counters = 0
  - rise_o = fall_o = 0
- Synchronizer: d_i passes through 2 flops. s = second-flop output, valid 2 edges after d_i is sampled.
- Per channel i, at each posedge:
  - en_i[i]=0: cnt<=0; q_o[i] holds; no events.
  - en_i[i]=1 and s[i]==q_o[i]: cnt<=0 (mismatch run broken).
  - en_i[i]=1, s[i]!=q_o[i], cnt>=T: q_o[i]<=s[i]; cnt<=0; rise_o[i] or fall_o[i] <= 1, matching the direction.
  - en_i[i]=1, s[i]!=q_o[i], cnt<T: cnt<=cnt+1.
  - rise_o/fall_o are registered; they are 0 on every edge that does not update q_o.
- Latency and filtering:
  - A change needs T+1 consecutive mismatch cycles at s.
  - If d_i is stable from edge 1, s changes at edge 2 and q_o changes at edge 3+T.
  - An event pulse is high in the same cycle q_o first shows the new value.
  - T=0 gives pure 2-sync plus 1 register: q_o follows d_i 3 edges later.
  - A pulse on s lasting <=T cycles never reaches q_o, and the counter clears when it ends.
- Boundaries:
  - cnt never exceeds max(T, previous T); width CntWidth; no overflow or wrap.
  - If thresh_i drops below the current cnt, the `>=` compare updates q_o on the next mismatch cycle.
  - Raising thresh_i mid-count extends the required run.
  - Deasserting en_i mid-count discards the count.
  - Re-enabling starts counting from 0 and never emits events for changes seen while disabled, until the run completes.
  - rise_o and fall_o are never both 1 on one channel.
  - Channels are fully independent; simultaneous events on several bits are all reported in the same cycle.
  - Reset mid-count returns the channel to the reset state immediately; no event is emitted.

Decomposition:
- Shared package prim_sync_debounce_pkg:
  - default CntWidth constant
  - typedef cnt_t = logic [CntWidth-1:0]
  - per-channel state struct {q, cnt}
- Sub-module: instance of prim_flop_2sync (Width=Width, ResetValue=ResetValue) for the synchronizer.
- Per-channel counter/compare is a generate loop inside this block, not a separate module.

Test Plan:
- Reset with ResetValue=0, en=all 1, T=3, d_i=0 -> q_o=0, rise_o=fall_o=0, and they stay 0 for 10 cycles.
- T=3, d_i[0] 0->1 held -> q_o[0]=1 at edge 6 after the change, rise_o[0]=1 for exactly that cycle; other bits unchanged.
- T=3, d_i[1] 3-cycle high glitch -> q_o[1] stays 0, no events, cnt returns to 0; a 4-cycle glitch produces rise then, 4 cycles later, fall.
- T=0, toggle d_i[2] every 2 cycles -> q_o[2] tracks d_i delayed 3 edges, alternating rise/fall pulses.
- T=7, d_i[3] high and cnt reaches 5, then thresh_i=2 -> q_o[3]=1 on the next edge; separately, en_i[3]=0 at cnt=5 then re-enabled -> 8 further cycles needed.
- Assert rst_ni low mid-count on all channels with d_i=all 1 -> q_o, rise_o, fall_o return to 0 asynchronously; after release, q_o=all 1 at edge 3+T.

Source files
------------

// File: rtl/prim_sync_debounce_pkg.sv
// Shared types for the multi-channel synchronizing debouncer.
package prim_sync_debounce_pkg;

  localparam int unsigned CntWidthDefault = 4;

  typedef logic [CntWidthDefault-1:0] cnt_t;

  typedef struct packed {
    logic q;
    cnt_t cnt;
  } chan_state_t;

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer for a vector of independent asynchronous bits.
module prim_flop_2sync #(
  parameter int unsigned Width      = 8,
  parameter logic        ResetValue = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] f1_q;
  logic [Width-1:0] f2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f1_q <= {Width{ResetValue}};
      f2_q <= {Width{ResetValue}};
    end else begin
      f1_q <= d_i;
      f2_q <= f1_q;
    end
  end

  assign q_o = f2_q;

endmodule

// File: rtl/prim_sync_debounce.sv
// Synchronizes each input bit and accepts a new level only after it
// has mismatched the filtered level for thresh_i+1 consecutive cycles.
module prim_sync_debounce
  import prim_sync_debounce_pkg::*;
#(
  parameter int unsigned Width      = 8,
  parameter int unsigned CntWidth   = CntWidthDefault,
  parameter logic        ResetValue = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [Width-1:0]    d_i,
  input  logic [Width-1:0]    en_i,
  input  logic [CntWidth-1:0] thresh_i,
  output logic [Width-1:0]    q_o,
  output logic [Width-1:0]    rise_o,
  output logic [Width-1:0]    fall_o
);

  typedef struct packed {
    logic                q;
    logic [CntWidth-1:0] cnt;
  } ch_t;

  logic [Width-1:0] s;

  prim_flop_2sync #(
    .Width      (Width),
    .ResetValue (ResetValue)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (d_i),
    .q_o    (s)
  );

  for (genvar i = 0; i < Width; i++) begin : g_ch
    ch_t  st_d, st_q;
    logic rise_d, rise_q;
    logic fall_d, fall_q;

    // >= rather than == so a lowered threshold releases a long run at once
    always_comb begin
      st_d   = st_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (!en_i[i]) begin
        st_d.cnt = '0;
      end else if (s[i] == st_q.q) begin
        st_d.cnt = '0;
      end else if (st_q.cnt >= thresh_i) begin
        st_d.q   = s[i];
        st_d.cnt = '0;
        rise_d   = s[i];
        fall_d   = ~s[i];
      end else begin
        st_d.cnt = st_q.cnt + 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        st_q.q   <= ResetValue;
        st_q.cnt <= '0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else begin
        st_q     <= st_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
      end
    end

    assign q_o[i]    = st_q.q;
    assign rise_o[i] = rise_q;
    assign fall_o[i] = fall_q;
  end

endmodule

// File: tb/tb_prim_sync_debounce.sv
// Directed scoreboard bench for prim_sync_debounce (Width=8, CntWidth=4).
module tb_prim_sync_debounce;

  logic       clk;
  logic       rst_n;
  logic [7:0] d;
  logic [7:0] en;
  logic [3:0] thr;
  logic [7:0] q;
  logic [7:0] rise;
  logic [7:0] fall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic [7:0] r;
    logic [7:0] f;
  } exp_t;

  exp_t sb[$];

  prim_sync_debounce #(
    .Width      (8),
    .CntWidth   (4),
    .ResetValue (1'b0)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .d_i      (d),
    .en_i     (en),
    .thresh_i (thr),
    .q_o      (q),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [7:0] eq,
                      input logic [7:0] er, input logic [7:0] ef);
    exp_t e;
    e.tag = tag;
    e.q   = eq;
    e.r   = er;
    e.f   = ef;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty got q=%h r=%h f=%h required an expectation",
             q, rise, fall);
    end else begin
      e = sb.pop_front();
      assert ({q, rise, fall} === {e.q, e.r, e.f}) else begin
        errors++;
        $error("FAIL %s got q=%h r=%h f=%h required q=%h r=%h f=%h",
               e.tag, q, rise, fall, e.q, e.r, e.f);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic run(input int n, input string tag, input logic [7:0] eq,
                     input logic [7:0] er, input logic [7:0] ef);
    for (int k = 0; k < n; k++) push(tag, eq, er, ef);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    logic p;
    logic prev;

    rst_n = 1'b0;
    d     = 8'h00;
    en    = 8'hFF;
    thr   = 4'd3;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    push("reset", 8'h00, 8'h00, 8'h00);
    check_now();
    @(negedge clk);
    rst_n = 1'b1;
    run(10, "idle", 8'h00, 8'h00, 8'h00);

    // T=3 rising edge on ch0
    d = 8'h01;
    run(5, "t3_wait", 8'h00, 8'h00, 8'h00);
    run(1, "t3_rise", 8'h01, 8'h01, 8'h00);
    run(2, "t3_hold", 8'h01, 8'h00, 8'h00);

    // 3-cycle glitch on ch1 is rejected
    d = 8'h03;
    run(3, "g3_in", 8'h01, 8'h00, 8'h00);
    d = 8'h01;
    run(8, "g3_rej", 8'h01, 8'h00, 8'h00);

    // 4-cycle glitch passes: rise then fall 4 cycles later
    d = 8'h03;
    run(4, "g4_in", 8'h01, 8'h00, 8'h00);
    d = 8'h01;
    run(1, "g4_e5", 8'h01, 8'h00, 8'h00);
    run(1, "g4_rise", 8'h03, 8'h02, 8'h00);
    run(3, "g4_high", 8'h03, 8'h00, 8'h00);
    run(1, "g4_fall", 8'h01, 8'h00, 8'h02);
    run(2, "g4_low", 8'h01, 8'h00, 8'h00);

    // T=0: ch2 toggles every 2 cycles, q follows 3 edges later
    thr  = 4'd0;
    prev = 1'b0;
    push("t0_pre", 8'h01, 8'h00, 8'h00);
    push("t0_pre", 8'h01, 8'h00, 8'h00);
    for (int c = 0; c < 12; c++) begin
      p = ((c / 2) % 2) == 0;
      d = 8'h01 | {5'd0, p, 2'd0};
      push("t0_track", 8'h01 | {5'd0, p, 2'd0},
           {5'd0, p & ~prev, 2'd0}, {5'd0, ~p & prev, 2'd0});
      prev = p;
      step();
    end
    step();
    step();

    // T=7 run on ch3, threshold dropped to 2 at cnt=5
    thr = 4'd7;
    d   = 8'h09;
    run(7, "thr_cnt", 8'h01, 8'h00, 8'h00);
    thr = 4'd2;
    run(1, "thr_drop", 8'h09, 8'h08, 8'h00);
    run(1, "thr_hold", 8'h09, 8'h00, 8'h00);

    // T=7, disable ch3 at cnt=5, re-enable needs 8 fresh cycles
    thr = 4'd7;
    d   = 8'h01;
    run(7, "en_cnt", 8'h09, 8'h00, 8'h00);
    en  = 8'hF7;
    run(3, "en_off", 8'h09, 8'h00, 8'h00);
    en  = 8'hFF;
    run(7, "en_recnt", 8'h09, 8'h00, 8'h00);
    run(1, "en_fall", 8'h01, 8'h00, 8'h08);
    run(1, "en_hold", 8'h01, 8'h00, 8'h00);

    // async reset mid-count, then all channels rise together
    thr = 4'd3;
    d   = 8'hFF;
    run(3, "rst_cnt", 8'h01, 8'h00, 8'h00);
    push("rst_async", 8'h00, 8'h00, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check_now();
    run(2, "rst_held", 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    run(5, "rst_wait", 8'h00, 8'h00, 8'h00);
    run(1, "rst_rise", 8'hFF, 8'hFF, 8'h00);
    run(2, "rst_hold", 8'hFF, 8'h00, 8'h00);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_left got %0d entries required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
